// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- single-issue ALU execution unit with valid/ready handshakes.
//
// Accepts one operation when in_valid && in_ready, computes it and presents the
// result with out_valid until the consumer takes it with out_ready.
// Non-shift ops (and shifts by zero) complete in one cycle. Shifts use a
// one-bit-per-cycle iterative shifter, so latency is shamt+1.
//
// Build option:
//   ALU_BARREL_SHIFT_EN  - when defined, shifts are computed combinationally
//                          with latency 1 and the SHIFT state is never entered.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   operation request valid
//   in_ready     out  unit can accept a request this cycle
//   alu_control  in   [3:0] operation code (ALU_* encoding below)
//   op_a, op_b   in   [31:0] operands; shift amount is op_b[4:0]
//   out_valid    out  result valid
//   out_ready    in   consumer accepts result
//   result       out  [31:0] operation result
//   zero         out  result == 0
//   illegal      out  accepted code was not a defined ALU_* value
//
// ALU_* encoding: ADD=0x0 SLL=0x1 SLT=0x2 SLTU=0x3 XOR=0x4 SRL=0x5 OR=0x6
//                 AND=0x7 SUB=0x8 SRA=0xD; all other codes are illegal.

module alu_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_control,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal
);

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SLL  = 4'h1;
    localparam logic [3:0] ALU_SLT  = 4'h2;
    localparam logic [3:0] ALU_SLTU = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SRL  = 4'h5;
    localparam logic [3:0] ALU_OR   = 4'h6;
    localparam logic [3:0] ALU_AND  = 4'h7;
    localparam logic [3:0] ALU_SUB  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_illegal;
    logic [31:0] r_work;
    logic [4:0]  r_cnt;
    logic [3:0]  r_shop;

    state_t      w_state_next;
    logic [31:0] w_result_next;
    logic        w_zero_next;
    logic        w_illegal_next;
    logic [31:0] w_work_next;
    logic [4:0]  w_cnt_next;
    logic [3:0]  w_shop_next;

    logic        w_accept;
    logic [4:0]  w_shamt;
    logic        w_legal;
    logic        w_is_shift;
    logic        w_go_iterative;
    logic [31:0] w_alu_result;
    logic [31:0] w_work_step;

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

    assign w_accept = in_valid && in_ready;
    assign w_shamt  = op_b[4:0];

    always_comb begin
        w_legal    = 1'b1;
        w_is_shift = 1'b0;
        case (alu_control)
            ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU,
            ALU_XOR, ALU_OR, ALU_AND:          w_is_shift = 1'b0;
            ALU_SLL, ALU_SRL, ALU_SRA:         w_is_shift = 1'b1;
            default:                           w_legal    = 1'b0;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN
    assign w_go_iterative = 1'b0;
`else
    // A zero shift amount needs no iterations, so it completes like any other
    // single-cycle op (the one-cycle datapath simply passes op_a through).
    assign w_go_iterative = w_legal && w_is_shift && (w_shamt != 5'd0);
`endif

    // Single-cycle datapath, evaluated on the request inputs at acceptance.
    always_comb begin
        w_alu_result = 32'd0;
        case (alu_control)
            ALU_ADD:  w_alu_result = op_a + op_b;
            ALU_SUB:  w_alu_result = op_a - op_b;
            ALU_SLT:  w_alu_result = {31'd0, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: w_alu_result = {31'd0, (op_a < op_b)};
            ALU_XOR:  w_alu_result = op_a ^ op_b;
            ALU_OR:   w_alu_result = op_a | op_b;
            ALU_AND:  w_alu_result = op_a & op_b;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL:  w_alu_result = op_a << w_shamt;
            ALU_SRL:  w_alu_result = op_a >> w_shamt;
            ALU_SRA:  w_alu_result = 32'($signed(op_a) >>> w_shamt);
`else
            // Only reached here with a zero shift amount.
            ALU_SLL, ALU_SRL, ALU_SRA: w_alu_result = op_a;
`endif
            default:  w_alu_result = 32'd0;
        endcase
    end

    // One-bit step of the iterative shifter.
    always_comb begin
        w_work_step = r_work;
        case (r_shop)
            ALU_SLL: w_work_step = {r_work[30:0], 1'b0};
            ALU_SRL: w_work_step = {1'b0, r_work[31:1]};
            ALU_SRA: w_work_step = {r_work[31], r_work[31:1]};
            default: w_work_step = r_work;
        endcase
    end

    always_comb begin
        w_state_next   = r_state;
        w_result_next  = r_result;
        w_zero_next    = r_zero;
        w_illegal_next = r_illegal;
        w_work_next    = r_work;
        w_cnt_next     = r_cnt;
        w_shop_next    = r_shop;

        case (r_state)
            ST_SHIFT: begin
                w_work_next = w_work_step;
                w_cnt_next  = r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    w_state_next  = ST_DONE;
                    w_result_next = w_work_step;
                    w_zero_next   = (w_work_step == 32'd0);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
            end
        endcase

        // Acceptance only happens in IDLE or in DONE while the result is being
        // taken, so it safely overrides the transitions above.
        if (w_accept) begin
            w_illegal_next = !w_legal;
            if (w_go_iterative) begin
                w_state_next = ST_SHIFT;
                w_work_next  = op_a;
                w_cnt_next   = w_shamt;
                w_shop_next  = alu_control;
            end else begin
                w_state_next  = ST_DONE;
                w_result_next = w_alu_result;
                w_zero_next   = (w_alu_result == 32'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_result  <= 32'd0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_work    <= 32'd0;
            r_cnt     <= 5'd0;
            r_shop    <= 4'd0;
        end else begin
            r_state   <= w_state_next;
            r_result  <= w_result_next;
            r_zero    <= w_zero_next;
            r_illegal <= w_illegal_next;
            r_work    <= w_work_next;
            r_cnt     <= w_cnt_next;
            r_shop    <= w_shop_next;
        end
    end

endmodule
